hex_word_uart_tx: RTL and testbench

HEX_WORD_UART_TX -- requirements
Module: hex_word_uart_tx

---
 rtl/hex_word_uart_tx.sv | 133 +++++++++++++
 tb/tb_hex_word_uart_tx.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_word_uart_tx.sv
// Sends a C_WIDTH-bit word as uppercase ASCII hex followed by CR LF over a UART line.
// Define HEX_WORD_UART_TX_PARITY_EN to append an even-parity bit to every character.
module hex_word_uart_tx #(
  parameter int C_FCK         = 48_000_000,
  parameter int C_BAUD_RATE   = 19_200,
  parameter int C_WIDTH       = 32,
  parameter int C_STOP_BITS   = 1,
  parameter int C_AUTO_REPEAT = 0
) (
  input  logic               CK_i,
  input  logic               XARST_i,
  input  logic               CK_EE_i,
  input  logic [C_WIDTH-1:0] DAT_i,
  input  logic               REQ_i,
  output logic               ACK_o,
  output logic               BUSY_o,
  output logic               DONE_o,
  output logic               TXD_o
);

  localparam int C_DIV_LEN = C_FCK / C_BAUD_RATE;
`ifdef HEX_WORD_UART_TX_PARITY_EN
  localparam int C_PAR = 1;
`else
  localparam int C_PAR = 0;
`endif
  localparam int C_FRAME = 9 + C_PAR + C_STOP_BITS;
  localparam int C_NCHR  = C_WIDTH / 4 + 2;
  localparam int C_PW    = $clog2(C_DIV_LEN);
  localparam int C_CW    = $clog2(C_NCHR);

  localparam logic [C_PW-1:0] C_PRE_LAST = C_PW'(C_DIV_LEN - 1);
  localparam logic [3:0]      C_BIT_LAST = 4'(C_FRAME - 1);
  localparam logic [C_CW-1:0] C_CHR_LAST = C_CW'(C_NCHR - 1);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t             r_state;
  logic [C_WIDTH-1:0] r_word;
  logic [C_PW-1:0]    r_pre;
  logic [3:0]         r_bit;
  logic [C_CW-1:0]    r_chr;
  logic               r_txd;
  logic               r_ack;
  logic               r_busy;
  logic               r_done;

  // Character idx of the message: hex digits MSB nibble first, then CR, then LF.
  function automatic logic [7:0] charOf(input logic [C_WIDTH-1:0] word,
                                        input logic [C_CW-1:0] idx);
    logic [C_WIDTH-1:0] sh;
    logic [3:0]         nib;
    if (idx == C_CW'(C_NCHR - 2)) return 8'h0D;
    if (idx == C_CW'(C_NCHR - 1)) return 8'h0A;
    sh  = word >> (C_WIDTH - 4 - 4 * int'(idx));
    nib = sh[3:0];
    return (nib < 4'd10) ? {4'h3, nib} : (8'h37 + {4'h0, nib});
  endfunction

  // Line level for frame position b: start, data LSB first, optional parity, stops.
  function automatic logic bitOf(input logic [7:0] ch, input logic [3:0] b);
    logic [2:0] k;
    k = 3'(b - 4'd1);
    if (b == 4'd0) return 1'b0;
    if (b <= 4'd8) return ch[k];
    if (C_PAR != 0 && b == 4'd9) return ^ch;
    return 1'b1;
  endfunction

  // TXD is registered from the next bit position so it changes exactly on the bit edge.
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      r_state <= S_IDLE;
      r_word  <= '0;
      r_pre   <= '0;
      r_bit   <= '0;
      r_chr   <= '0;
      r_txd   <= 1'b1;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_ack  <= 1'b0;
      r_done <= 1'b0;
      if (CK_EE_i) begin
        case (r_state)
          S_IDLE: begin
            if (REQ_i || C_AUTO_REPEAT != 0) begin
              r_word  <= DAT_i;
              r_state <= S_SEND;
              r_pre   <= '0;
              r_bit   <= '0;
              r_chr   <= '0;
              r_txd   <= 1'b0;
              r_ack   <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
          S_SEND: begin
            if (r_pre == C_PRE_LAST) begin
              r_pre <= '0;
              if (r_bit == C_BIT_LAST) begin
                r_bit <= '0;
                if (r_chr == C_CHR_LAST) begin
                  r_chr   <= '0;
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_txd   <= 1'b1;
                end else begin
                  r_chr <= r_chr + 1'b1;
                  r_txd <= 1'b0;
                end
              end else begin
                r_bit <= r_bit + 4'd1;
                r_txd <= bitOf(charOf(r_word, r_chr), r_bit + 4'd1);
              end
            end else begin
              r_pre <= r_pre + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign ACK_o  = r_ack;
  assign BUSY_o = r_busy;
  assign DONE_o = r_done;
  assign TXD_o  = r_txd;

endmodule

// File: tb/tb_hex_word_uart_tx.sv
// Scoreboard bench for hex_word_uart_tx: a UART decoder and a busy/ack/done monitor
// compare the line against expected characters queued when each message is requested.
module tb_hex_word_uart_tx;

  localparam int FCK    = 10_000;
  localparam int BAUD   = 300;
  localparam int DIV    = FCK / BAUD;
  localparam int W      = 32;
  localparam int STOPS  = 1;
  localparam int NCH    = W / 4 + 2;
`ifdef HEX_WORD_UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int F      = 9 + PAR + STOPS;
  localparam int MSGLEN = NCH * F * DIV;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst2, ckEe, req, sel;
  logic [31:0] dat, dat2;
  logic        ack, busy, done, txd;
  logic        ack2, busy2, done2, txd2;
  logic        sAck, sBusy, sDone, sTxd, sRst;
  logic        enAtEdge;

  hex_word_uart_tx #(.C_FCK(FCK), .C_BAUD_RATE(BAUD), .C_WIDTH(W),
                     .C_STOP_BITS(STOPS), .C_AUTO_REPEAT(0)) dut (
    .CK_i(clk), .XARST_i(rst), .CK_EE_i(ckEe), .DAT_i(dat), .REQ_i(req),
    .ACK_o(ack), .BUSY_o(busy), .DONE_o(done), .TXD_o(txd));

  hex_word_uart_tx #(.C_FCK(FCK), .C_BAUD_RATE(BAUD), .C_WIDTH(W),
                     .C_STOP_BITS(STOPS), .C_AUTO_REPEAT(1)) dutAuto (
    .CK_i(clk), .XARST_i(rst2), .CK_EE_i(ckEe), .DAT_i(dat2), .REQ_i(1'b0),
    .ACK_o(ack2), .BUSY_o(busy2), .DONE_o(done2), .TXD_o(txd2));

  assign sAck  = sel ? ack2  : ack;
  assign sBusy = sel ? busy2 : busy;
  assign sDone = sel ? done2 : done;
  assign sTxd  = sel ? txd2  : txd;
  assign sRst  = sel ? rst2  : rst;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  expQ[$];
  int          lenQ[$];
  int          ackCnt = 0;
  int          doneCnt = 0;
  int          a0, d0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hexChar(input logic [3:0] n);
    int v;
    if (n < 4'd10) v = 48 + int'(n);
    else v = 65 + (int'(n) - 10);
    return 8'(v);
  endfunction

  function automatic logic [11:0] frameOf(input logic [7:0] b);
    logic [11:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = b;
    if (PAR != 0) f[9] = ^b;
    return f;
  endfunction

  task automatic pushMessage(input logic [31:0] w, input int extra);
    for (int i = 0; i < W / 4; i++) expQ.push_back(hexChar(4'((w >> (W - 4 - 4 * i)) & 32'hF)));
    expQ.push_back(8'h0D);
    expQ.push_back(8'h0A);
    lenQ.push_back(MSGLEN + extra);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitDone(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sDone && n < MSGLEN + 400);
    if (!sDone) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s: DONE_o not seen within %0d cycles", name, n);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] w, input int extra);
    pushMessage(w, extra);
    a0 = ackCnt;
    d0 = doneCnt;
    @(negedge clk);
    dat = w;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    dat = $urandom;
  endtask

  task automatic finishWord(input int expAcks, input int expDones);
    waitDone("message done");
    @(negedge clk);
    #1;
    checkOutput("ack count", 64'(ackCnt - a0), 64'(expAcks));
    checkOutput("done count", 64'(doneCnt - d0), 64'(expDones));
    checkOutput("queue drained", 64'(expQ.size()), 64'd0);
  endtask

  initial forever begin
    @(posedge clk);
    enAtEdge = ckEe;
  end

  // UART decoder: counts enabled edges from the start bit and samples mid-bit.
  initial begin
    logic        active;
    int          pos, bi;
    logic [11:0] got;
    active = 1'b0;
    pos = 0;
    bi = 0;
    got = '1;
    forever begin
      @(negedge clk);
      if (!sRst) begin
        active = 1'b0;
      end else if (!active) begin
        if (sTxd == 1'b0) begin
          active = 1'b1;
          pos = 0;
          bi = 0;
          got = '1;
        end
      end else if (enAtEdge) begin
        pos++;
        if (pos == bi * DIV + DIV / 2) begin
          got[bi] = sTxd;
          bi++;
          if (bi == F) begin
            active = 1'b0;
            if (expQ.size() == 0) begin
              tests++;
              fails++;
              $display("[TB] FAIL unexpected char: got frame %0h, nothing expected", got);
            end else begin
              checkOutput("char frame", 64'(got), 64'(frameOf(expQ.pop_front())));
            end
          end
        end
      end
    end
  end

  // Busy-length, pulse-width and pulse-count monitor.
  initial begin
    logic prevBusy, prevAck, prevDone;
    int   run;
    prevBusy = 1'b0;
    prevAck = 1'b0;
    prevDone = 1'b0;
    run = 0;
    forever begin
      @(negedge clk);
      if (!sRst) begin
        run = 0;
        prevBusy = 1'b0;
        prevAck = 1'b0;
        prevDone = 1'b0;
      end else begin
        if (sBusy) run++;
        if (prevBusy && !sBusy) begin
          checkOutput("done at busy fall", 64'(sDone), 64'd1);
          if (lenQ.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL busy length: got %0d cycles, no message expected", run);
          end else begin
            checkOutput("busy length", 64'(run), 64'(lenQ.pop_front()));
          end
          run = 0;
        end
        if (sAck) begin
          ackCnt++;
          checkOutput("ack pulse width", 64'(prevAck), 64'd0);
        end
        if (sDone) begin
          doneCnt++;
          checkOutput("done pulse width", 64'(prevDone), 64'd0);
        end
        prevBusy = sBusy;
        prevAck = sAck;
        prevDone = sDone;
      end
    end
  end

  initial begin
    logic [31:0] w;
    logic        held;
    int          bad;
    rst = 1'b1;
    rst2 = 1'b1;
    ckEe = 1'b1;
    req = 1'b0;
    sel = 1'b0;
    dat = '0;
    dat2 = 32'hFFFF_FFFF;
    #1;
    rst = 1'b0;
    rst2 = 1'b0;
    waitCycles(3);
    checkOutput("reset txd", 64'(txd), 64'd1);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset ack", 64'(ack), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    rst = 1'b1;
    waitCycles(3);
    checkOutput("idle busy", 64'(busy), 64'd0);
    checkOutput("idle txd", 64'(txd), 64'd1);

    $display("[TB] directed word 1234ABCD");
    applyStimulus(32'h1234_ABCD, 0);
    finishWord(1, 1);

    $display("[TB] random words with DAT_i churn and ignored REQ_i");
    for (int k = 0; k < 4; k++) begin
      applyStimulus($urandom, 0);
      waitCycles(1000);
      req = 1'b1;
      dat = $urandom;
      @(negedge clk);
      req = 1'b0;
      dat = $urandom;
      finishWord(1, 1);
    end

    $display("[TB] clock-enable freeze");
    applyStimulus($urandom, 50);
    waitCycles(700 + $urandom_range(0, 20));
    ckEe = 1'b0;
    held = txd;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (txd !== held) bad++;
    end
    ckEe = 1'b1;
    checkOutput("txd held while frozen", 64'(bad), 64'd0);
    finishWord(1, 1);

    $display("[TB] REQ_i held high");
    w = $urandom;
    pushMessage(w, 0);
    pushMessage(w, 0);
    a0 = ackCnt;
    d0 = doneCnt;
    @(negedge clk);
    dat = w;
    req = 1'b1;
    waitDone("held first done");
    @(negedge clk);
    checkOutput("held ack spacing", 64'(ack), 64'd1);
    req = 1'b0;
    finishWord(2, 2);

    $display("[TB] reset mid-message");
    applyStimulus($urandom, 0);
    waitCycles(500);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("abort txd", 64'(txd), 64'd1);
    checkOutput("abort busy", 64'(busy), 64'd0);
    expQ.delete();
    lenQ.delete();
    d0 = doneCnt;
    waitCycles(3);
    #1;
    checkOutput("no done on abort", 64'(doneCnt - d0), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    waitCycles(2);
    applyStimulus($urandom, 0);
    finishWord(1, 1);

    $display("[TB] auto repeat");
    @(negedge clk);
    sel = 1'b1;
    pushMessage(dat2, 0);
    pushMessage(dat2, 0);
    pushMessage(dat2, 0);
    a0 = ackCnt;
    d0 = doneCnt;
    @(negedge clk);
    rst2 = 1'b1;
    waitDone("auto first done");
    @(negedge clk);
    checkOutput("auto ack spacing 1", 64'(sAck), 64'd1);
    waitDone("auto second done");
    @(negedge clk);
    checkOutput("auto ack spacing 2", 64'(sAck), 64'd1);
    waitCycles(300);
    #2;
    rst2 = 1'b0;
    expQ.delete();
    lenQ.delete();
    waitCycles(2);
    #1;
    checkOutput("auto ack count", 64'(ackCnt - a0), 64'd3);
    checkOutput("auto done count", 64'(doneCnt - d0), 64'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
